// File: rtl/disp_pkg.sv
// Shared types, constants and the hex-to-segment decoder for the display scan arbiter.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SCAN  = 2'd2
    } disp_state_t;

    // What the FSM does at the next tick.
    typedef enum logic [2:0] {
        ACT_HOLD  = 3'd0,
        ACT_BLANK = 3'd1,
        ACT_FRAME = 3'd2,
        ACT_STEP  = 3'd3,
        ACT_IDLE  = 3'd4
    } disp_action_t;

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Segments {a,b,c,d,e,f,g}, active-low.
    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/disp_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last grantee,
// so the last grantee only wins when nobody else is asking.
module disp_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    input  logic            exclude_last,
    output logic [NREQ-1:0] winner,
    output logic            any
);

    logic [NREQ-1:0] elig;
    int              idx;

    // NOTE: every combinational output gets a default before any conditional
    // assignment, otherwise synthesis infers a latch.
    always_comb begin
        elig   = req;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (exclude_last && i == int'(last)) elig[i] = 1'b0;
        end
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (elig[idx] && winner == '0) winner[idx] = 1'b1;
        end
    end

    assign any = |elig;

endmodule

// File: rtl/disp_scan_arbiter.sv
// Shares the 8-digit seven-segment display and LED bank among NREQ 32-bit
// requesters, scanning digits on a divided tick and rotating owners per frame.
module disp_scan_arbiter
    import disp_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int SCAN_DIV     = 500,
    parameter int DWELL_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 Rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   data,
    output logic [NREQ-1:0]      grant,
    output logic [7:0]           an,
    output logic [6:0]           sev_out,
    output logic [15:0]          led,
    output logic                 frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DWELL_FRAMES + 1);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [CW-1:0]   cnt;
    logic            tick;
    disp_state_t     state;
    disp_action_t    act;
    logic [2:0]      dig;
    logic [2:0]      next_dig;
    logic [DW-1:0]   dwell;
    logic [31:0]     snap;
    logic [IW-1:0]   last;
    logic [NREQ-1:0] winner;
    logic            any;
    logic [IW-1:0]   win_idx;
    logic [31:0]     own_data;
    logic            own_req;
    logic            others;
    logic            rotate_due;
    logic            dwell_sat;

    assign tick       = (cnt == CW'(SCAN_DIV - 1));
    assign next_dig   = dig + 3'd1;
    assign own_req    = |(req & grant);
    assign others     = |(req & ~grant);
    assign rotate_due = (int'(dwell) + 1) >= DWELL_FRAMES;
    assign dwell_sat  = int'(dwell) >= DWELL_FRAMES;

    disp_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req          (req),
        .last         (last),
        .exclude_last (state == SCAN),
        .winner       (winner),
        .any          (any)
    );

    always_comb begin
        win_idx  = '0;
        own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner[i]) win_idx = IW'(i);
            if (grant[i])  own_data = data[32*i +: 32];
        end
    end

    always_comb begin
        act = ACT_HOLD;
        unique case (state)
            IDLE:  if (any) act = ACT_BLANK;
            BLANK: act = ACT_FRAME;
            SCAN: begin
                if (dig == 3'd7) begin
                    if (others && rotate_due) act = ACT_BLANK;
                    else if (own_req)         act = ACT_FRAME;
                    else if (any)             act = ACT_BLANK;
                    else                      act = ACT_IDLE;
                end else if (!own_req) begin
                    // Owner left mid-frame: abandon the partial frame.
                    act = any ? ACT_BLANK : ACT_IDLE;
                end else begin
                    act = ACT_STEP;
                end
            end
            default: act = ACT_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) cnt <= '0;
        else if (tick) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            grant      <= '0;
            an         <= AN_OFF;
            sev_out    <= SEG_OFF;
            led        <= '0;
            frame_done <= 1'b0;
            dig        <= '0;
            dwell      <= '0;
            snap       <= '0;
            last       <= '0;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                if (state == SCAN && dig == 3'd7) begin
                    frame_done <= 1'b1;
                    if (!dwell_sat) dwell <= dwell + 1'b1;
                end
                unique case (act)
                    ACT_BLANK: begin
                        state   <= BLANK;
                        grant   <= winner;
                        last    <= win_idx;
                        dwell   <= '0;
                        an      <= AN_OFF;
                        sev_out <= SEG_OFF;
                        led     <= '0;
                    end
                    ACT_FRAME: begin
                        state   <= SCAN;
                        dig     <= '0;
                        snap    <= own_data;
                        an      <= 8'hFE;
                        sev_out <= hex7seg(own_data[3:0]);
                        led     <= own_data[15:0];
                    end
                    ACT_STEP: begin
                        dig     <= next_dig;
                        an      <= ~(8'd1 << next_dig);
                        sev_out <= hex7seg(snap[{next_dig, 2'b00} +: 4]);
                    end
                    ACT_IDLE: begin
                        state   <= IDLE;
                        grant   <= '0;
                        an      <= AN_OFF;
                        sev_out <= SEG_OFF;
                        led     <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_arbiter.sv
// Scoreboard bench for disp_scan_arbiter with SCAN_DIV=4, DWELL_FRAMES=2, NREQ=2.
module tb_disp_scan_arbiter;

    localparam int SD = 4;
    localparam int K_IDLE  = 0;
    localparam int K_BLANK = 1;
    localparam int K_DIG   = 2;
    localparam logic [31:0] D0A = 32'h89AB_CDEF;
    localparam logic [31:0] D0B = 32'hCAFE_F00D;
    localparam logic [31:0] D1  = 32'h1234_5678;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct {
        logic [7:0]  an;
        logic [6:0]  sev;
        logic [1:0]  grant;
        logic [15:0] led;
        logic        fd;
        logic        chk_led;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [63:0] data = '0;
    logic [1:0]  grant;
    logic [7:0]  an;
    logic [6:0]  sev_out;
    logic [15:0] led;
    logic        frame_done;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc;
    logic pend_fd = 1'b0;
    exp_t sb_q[$];
    exp_t mon_e;

    disp_scan_arbiter #(.NREQ(2), .SCAN_DIV(SD), .DWELL_FRAMES(2)) dut (
        .clk        (clk),
        .Rst        (rst),
        .req        (req),
        .data       (data),
        .grant      (grant),
        .an         (an),
        .sev_out    (sev_out),
        .led        (led),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Bench-side cycle count since reset release; slot edges are multiples of SD.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && cyc != 0) begin
            if (cyc % SD == 0) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("an",         32'(an),         32'(mon_e.an));
                    check("sev_out",    32'(sev_out),    32'(mon_e.sev));
                    check("grant",      32'(grant),      32'(mon_e.grant));
                    check("frame_done", 32'(frame_done), 32'(mon_e.fd));
                    if (mon_e.chk_led) check("led", 32'(led), 32'(mon_e.led));
                end
            end else begin
                check("frame_done_quiet", 32'(frame_done), 32'd0);
            end
        end
    end

    task automatic push_exp(input int kind, input int dg, input logic [31:0] snapv,
                            input logic [1:0] g);
        exp_t       e;
        logic [3:0] nib;
        e.fd      = pend_fd;
        pend_fd   = 1'b0;
        e.grant   = (kind == K_IDLE) ? 2'b00 : g;
        e.chk_led = (kind != K_BLANK);
        if (kind == K_DIG) begin
            nib     = snapv[4*dg +: 4];
            e.an    = ~(8'd1 << dg);
            e.sev   = SEG_TAB[nib];
            e.led   = snapv[15:0];
            pend_fd = (dg == 7);
        end else begin
            e.an  = 8'hFF;
            e.sev = 7'h7F;
            e.led = 16'h0000;
        end
        sb_q.push_back(e);
    endtask

    task automatic wait_slot();
        do @(negedge clk); while (cyc % SD != 0);
        #1;
    endtask

    // Drive inputs for the next tick and queue what that tick must produce.
    task automatic go(input logic [1:0] r, input logic [31:0] a, input logic [31:0] b,
                      input int kind, input int dg, input logic [31:0] snapv,
                      input logic [1:0] g);
        wait_slot();
        req  = r;
        data = {b, a};
        push_exp(kind, dg, snapv, g);
    endtask

    task automatic check_reset_values();
        check("rst_an",    32'(an),         32'hFF);
        check("rst_sev",   32'(sev_out),    32'h7F);
        check("rst_grant", 32'(grant),      32'd0);
        check("rst_led",   32'(led),        32'd0);
        check("rst_fd",    32'(frame_done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #1 check_reset_values();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Nobody requests for 100 cycles.
        push_exp(K_IDLE, 0, 0, 2'b00);
        repeat (24) go(2'b00, 0, 0, K_IDLE, 0, 0, 2'b00);

        // Single requester: blank slot, then full frames.
        go(2'b01, D0A, D1, K_BLANK, 0, 0, 2'b01);
        for (int d = 0; d < 8; d++) go(2'b01, D0A, D1, K_DIG, d, D0A, 2'b01);
        // Data changes mid-frame must not tear the frame in progress.
        for (int d = 0; d < 8; d++) go(2'b01, (d < 3) ? D0A : 32'h0, D1, K_DIG, d, D0A, 2'b01);
        for (int d = 0; d < 8; d++) go((d < 2) ? 2'b01 : 2'b11, 32'h0, D1, K_DIG, d, 32'h0, 2'b01);

        // Contention: owner 0 has dwelt long enough, rotate to 1 for two frames, then back.
        go(2'b11, D0B, D1, K_BLANK, 0, 0, 2'b10);
        for (int f = 0; f < 2; f++)
            for (int d = 0; d < 8; d++) go(2'b11, D0B, D1, K_DIG, d, D1, 2'b10);
        go(2'b11, D0B, D1, K_BLANK, 0, 0, 2'b01);
        for (int d = 0; d < 5; d++) go(2'b11, D0B, D1, K_DIG, d, D0B, 2'b01);

        // Owner 0 drops after digit 4: abandon frame, no frame_done.
        go(2'b10, D0B, D1, K_BLANK, 0, 0, 2'b10);
        for (int d = 0; d < 8; d++) go(2'b10, D0B, D1, K_DIG, d, D1, 2'b10);
        for (int d = 0; d < 3; d++) go(2'b10, D0B, D1, K_DIG, d, D1, 2'b10);

        // Asynchronous reset mid-scan.
        @(negedge clk);
        #2 rst = 1'b1;
        sb_q.delete();
        pend_fd = 1'b0;
        #1 check_reset_values();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push_exp(K_BLANK, 0, 0, 2'b10);
        for (int d = 0; d < 8; d++) go(2'b10, D0B, D1, K_DIG, d, D1, 2'b10);
        go(2'b10, D0B, D1, K_DIG, 0, D1, 2'b10);
        wait_slot();
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_scan_arbiter.md
# disp_scan_arbiter

Shares the board's 8-digit seven-segment display and LED bank among several 32-bit requesters, such as the core debug word and UART status. It replaces the ripple clock divider with a single-clock tick enable. It scans the digits, and it hands display ownership round-robin at frame boundaries. It sits beside `RISCVcore` in the top level and drives `an`, `sev_out` and `led` directly.

## Interface
- `NREQ`, default 2: number of requesters, 1..8.
- `SCAN_DIV`, default 500: clk cycles per digit slot, ≥2.
- `DWELL_FRAMES`, default 64: full 8-digit frames a grantee keeps the display before rotation is considered, ≥1.
- `clk`, in, 1: system clock. This is the only clock.
- `Rst`, in, 1: asynchronous, active-high reset.
- `req`, in, NREQ: request bit per source. Level-sensitive.
- `data`, in, 32*NREQ: source i value is on `data[32*i +: 32]`.
- `grant`, out, NREQ: one-hot owner. All zero when no source owns the display.
- `an`, out, 8: digit anodes, active-low, one-hot-low while scanning.
- `sev_out`, out, 7: segments `{a,b,c,d,e,f,g}`, active-low.
- `led`, out, 16: bits [15:0] of the owner's snapshot. Zero when there is no owner.
- `frame_done`, out, 1: one-cycle pulse when digit 7 finishes its slot.

## Operation
- Tick generator: `cnt` counts 0..SCAN_DIV-1 and then wraps. `tick` = (`cnt`==SCAN_DIV-1). All state below advances only on `tick`.
- FSM states:
  - IDLE: `an`=8'hFF, `grant`=0.
  - BLANK: exactly one slot, `an`=8'hFF. Prevents ghosting on owner change.
  - SCAN: digit index `dig` 0..7. `an` = ~(1<<dig). `sev_out` = hex of `snap[4*dig +: 4]`.
- IDLE→BLANK: on tick when `req`≠0. The arbiter picks the winner, `grant` updates and `dwell` clears.
- BLANK→SCAN: on the next tick. `dig`=0 and `snap` ← data of the grantee.
- SCAN, dig<7: on tick, `dig`++.
- SCAN, dig==7, on tick: `frame_done` pulses, `dwell`++ (saturating), then one of:
  - Another requester is waiting and `dwell`+1 ≥ DWELL_FRAMES: go to BLANK with the round-robin winner.
  - Otherwise, if the grantee still requests: `dig`=0 and `snap` ← fresh data.
  - Grantee dropped and nobody requests: go to IDLE.
  - Grantee dropped and another requests: go to BLANK with the winner.
- Grantee drops `req` mid-frame: on the next tick, go to BLANK with the new winner, or IDLE if nobody requests. The partial frame is abandoned and `frame_done` does not pulse.
- Round-robin search starts at (last grantee+1) mod NREQ. The last grantee is eligible only when it is the sole requester. After reset the pointer is 0.
- `snap` is loaded only at frame start. `data` changes mid-frame are not shown until the next frame (no tearing).
- Hex encoding:
  - 0→0000001, 1→1001111, 2→0010010, 3→0000110
  - 4→1001100, 5→0100100, 6→0100000, 7→0001111
  - 8→0000000, 9→0000100, A→0001000, b→1100000
  - C→0110001, d→1000010, E→0110000, F→0111000
- `sev_out`=7'h7F whenever `an`=8'hFF.

## Timing
- Reset values: `an`=8'hFF, `sev_out`=7'h7F, `grant`=0, `led`=0, `frame_done`=0, `cnt`=0, `dig`=0, `dwell`=0, `snap`=0, state IDLE, RR pointer 0.
- All outputs are registered. `an`, `sev_out`, `grant` and `led` change in the cycle after `tick`.
- Latency from `req` rising (idle display) to first lit digit: ≤ 2·SCAN_DIV+1 cycles. One slot is the IDLE wait; the BLANK slot adds one more.
- A frame is 8·SCAN_DIV cycles. The owner holds for ≥ DWELL_FRAMES frames when contended.
- If `req` toggles between ticks, only its value sampled at the tick matters.
- `Rst` asserted mid-frame blanks the display and clears `grant` immediately (asynchronous). Operation resumes from IDLE with `cnt`=0.

## Structure
- Package `disp_pkg`:
  - `disp_state_t` enum {IDLE, BLANK, SCAN}.
  - Constants AN_OFF=8'hFF and SEG_OFF=7'h7F.
  - Function `hex7seg(logic [3:0]) → logic [6:0]`.
- Sub-module `disp_rr_arbiter` (NREQ). Inputs: `req`, `last`, `exclude_last`. Outputs: `winner` (one-hot) and `any`. Purely combinational. The pointer register stays in the parent.
- The top-level instantiates this block in place of the inline scan logic. The core's debug word connects as requester 0.

## Test plan
Sim uses SCAN_DIV=4 and DWELL_FRAMES=2.
- Reset, then `req`=0 for 100 cycles → `an`=FF, `sev_out`=7F, `grant`=0, `frame_done` never pulses.
- `req`=01 with `data0`=32'h89ABCDEF → one BLANK slot, then `an` steps FE,FD,…,7F. Digit values are F,E,D,C,B,A,9,8, so `sev_out` is 0111000 first and 0000000 last. `led`=16'hCDEF. `frame_done` pulses every 32 cycles.
- `data0` changed to 32'h0 at digit 3 → remaining digits still show the old value. The next frame shows 0000001 on all digits.
- `req`=11 constant → `grant` alternates 01,10 every 2 frames, with one blank slot between owners.
- Grantee 0 drops `req` at digit 4 while `req1`=1 → next tick BLANK, then `grant`=10 from digit 0. No `frame_done` for the aborted frame.
- `Rst` pulse of 3 cycles mid-SCAN → outputs at reset values within the same cycle. Scanning restarts after ≤2 slots once `req` is still high.
